// File: rtl/fetch_stage.sv
// ============================================================================
// fetch_stage : MIPS instruction-fetch stage with PC, IF/ID register and an
//               optional one-entry skid buffer (enabled by FETCH_SKID_EN).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        Flush,
    input  logic [31:0] BranchTarget,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemData,
    output logic [31:0] IFInstruction,
    output logic [31:0] InstructionIFID,
    output logic [31:0] PCPlus4IFID,
    output logic        ValidIFID,
    output logic        SkidValid,
    output logic [31:0] FetchCount
);

    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] src_instr;
    logic [31:0] src_pc4;
    logic        load_ifid;
    logic        advance_pc;

    assign pc_plus4 = pc + 32'd4;
    assign IMemAddr = pc;

`ifdef FETCH_SKID_EN
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc4;
    logic        load_skid;

    always_comb begin
        load_ifid  = 1'b0;
        advance_pc = 1'b0;
        load_skid  = 1'b0;
        src_instr  = IMemData;
        src_pc4    = pc_plus4;
        if (skid_valid) begin
            src_instr = skid_instr;
            src_pc4   = skid_pc4;
        end
        if (PCWrite) begin
            load_ifid  = IFIDWrite;
            // While the skid holds a word the PC must wait for it to drain.
            advance_pc = !skid_valid;
            load_skid  = !IFIDWrite && !skid_valid;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            skid_valid <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc4   <= 32'd0;
        end else if (Flush) begin
            skid_valid <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc4   <= 32'd0;
        end else if (load_skid) begin
            skid_valid <= 1'b1;
            skid_instr <= IMemData;
            skid_pc4   <= pc_plus4;
        end else if (load_ifid) begin
            skid_valid <= 1'b0;
        end
    end

    assign SkidValid = skid_valid;
`else
    always_comb begin
        src_instr  = IMemData;
        src_pc4    = pc_plus4;
        // Without a skid buffer a frozen IF/ID must also freeze the PC.
        load_ifid  = PCWrite && IFIDWrite;
        advance_pc = PCWrite && IFIDWrite;
    end

    assign SkidValid = 1'b0;
`endif

    assign IFInstruction = src_instr;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            pc              <= RESET_PC;
            InstructionIFID <= 32'd0;
            PCPlus4IFID     <= 32'd0;
            ValidIFID       <= 1'b0;
            FetchCount      <= 32'd0;
        end else if (Flush) begin
            pc              <= {BranchTarget[31:2], 2'b00};
            InstructionIFID <= 32'd0;
            PCPlus4IFID     <= 32'd0;
            ValidIFID       <= 1'b0;
        end else begin
            if (advance_pc) begin
                pc <= pc_plus4;
            end
            if (load_ifid) begin
                InstructionIFID <= src_instr;
                PCPlus4IFID     <= src_pc4;
                ValidIFID       <= 1'b1;
                FetchCount      <= FetchCount + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (main instance RESET_PC=0x40,
// second instance RESET_PC=0xFFFF_FFFC for address wrap).
`default_nettype none

module tb_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        Flush;
    logic [31:0] BranchTarget;

    logic [31:0] IMemAddr, IMemData, IFInstruction, InstructionIFID, PCPlus4IFID, FetchCount;
    logic        ValidIFID, SkidValid;
    logic [31:0] w_IMemAddr, w_IMemData, w_IFInstruction, w_InstructionIFID, w_PCPlus4IFID, w_FetchCount;
    logic        w_ValidIFID, w_SkidValid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2002_0005;
        return a ^ 32'h8C00_0000;
    endfunction

    assign IMemData   = imem(IMemAddr);
    assign w_IMemData = imem(w_IMemAddr);

    fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .Flush(Flush), .BranchTarget(BranchTarget), .IMemAddr(IMemAddr),
        .IMemData(IMemData), .IFInstruction(IFInstruction),
        .InstructionIFID(InstructionIFID), .PCPlus4IFID(PCPlus4IFID),
        .ValidIFID(ValidIFID), .SkidValid(SkidValid), .FetchCount(FetchCount)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .Clk(Clk), .Rst_n(Rst_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .Flush(Flush), .BranchTarget(BranchTarget), .IMemAddr(w_IMemAddr),
        .IMemData(w_IMemData), .IFInstruction(w_IFInstruction),
        .InstructionIFID(w_InstructionIFID), .PCPlus4IFID(w_PCPlus4IFID),
        .ValidIFID(w_ValidIFID), .SkidValid(w_SkidValid), .FetchCount(w_FetchCount)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic pcw, input logic ifw, input logic fl);
        PCWrite   = pcw;
        IFIDWrite = ifw;
        Flush     = fl;
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0);
        BranchTarget = 32'd0;
        tick();
        tick();
        Rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (IMemAddr !== 32'h40) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", IMemAddr, 32'h40); end
        n_checks++; if (ValidIFID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", ValidIFID); end
        n_checks++; if (FetchCount !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", FetchCount); end
        n_checks++; if (InstructionIFID !== 32'd0 || PCPlus4IFID !== 32'd0) begin n_fail++; $display("FAIL reset_ifid: got %h/%h exp 0/0", InstructionIFID, PCPlus4IFID); end
        n_checks++; if (SkidValid !== 1'b0) begin n_fail++; $display("FAIL reset_skid: got %b exp 0", SkidValid); end
    endtask

    task automatic test_straight_line();
        logic [31:0] a;
        do_reset();
        drive(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (InstructionIFID !== 32'h2002_0005 || PCPlus4IFID !== 32'h44) begin n_fail++; $display("FAIL first_fetch: got %h/%h exp 20020005/00000044", InstructionIFID, PCPlus4IFID); end
        for (int i = 1; i < 8; i++) begin
            a = 32'h40 + 32'(i * 4);
            n_checks++; if (IMemAddr !== a) begin n_fail++; $display("FAIL line_addr[%0d]: got %h exp %h", i, IMemAddr, a); end
            tick();
            n_checks++; if (ValidIFID !== 1'b1 || InstructionIFID !== imem(a) || PCPlus4IFID !== a + 32'd4) begin n_fail++; $display("FAIL line_ifid[%0d]: got %b/%h/%h exp 1/%h/%h", i, ValidIFID, InstructionIFID, PCPlus4IFID, imem(a), a + 32'd4); end
        end
        n_checks++; if (FetchCount !== 32'd8 || IMemAddr !== 32'h60) begin n_fail++; $display("FAIL line_end: got cnt %0d pc %h exp 8 00000060", FetchCount, IMemAddr); end
    endtask

    task automatic test_load_use_stall();
        do_reset();
        tick();
        tick();
        drive(1'b0, 1'b0, 1'b0);
        tick();
        n_checks++; if (IMemAddr !== 32'h48) begin n_fail++; $display("FAIL stall_pc: got %h exp 00000048", IMemAddr); end
        n_checks++; if (InstructionIFID !== imem(32'h44) || PCPlus4IFID !== 32'h48 || FetchCount !== 32'd2) begin n_fail++; $display("FAIL stall_ifid: got %h/%h/%0d exp %h/00000048/2", InstructionIFID, PCPlus4IFID, FetchCount, imem(32'h44)); end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (InstructionIFID !== imem(32'h48) || IMemAddr !== 32'h4C || FetchCount !== 32'd3) begin n_fail++; $display("FAIL stall_resume: got %h/%h/%0d exp %h/0000004c/3", InstructionIFID, IMemAddr, FetchCount, imem(32'h48)); end
    endtask

    task automatic run_to_50();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_ifid_freeze();
        run_to_50();
        drive(1'b1, 1'b0, 1'b0);
        tick();
`ifdef FETCH_SKID_EN
        n_checks++; if (SkidValid !== 1'b1 || IMemAddr !== 32'h54) begin n_fail++; $display("FAIL skid_fill: got %b/%h exp 1/00000054", SkidValid, IMemAddr); end
        n_checks++; if (IFInstruction !== imem(32'h50) || InstructionIFID !== imem(32'h4C) || FetchCount !== 32'd4) begin n_fail++; $display("FAIL skid_hold: got %h/%h/%0d exp %h/%h/4", IFInstruction, InstructionIFID, FetchCount, imem(32'h50), imem(32'h4C)); end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (InstructionIFID !== imem(32'h50) || PCPlus4IFID !== 32'h54 || SkidValid !== 1'b0 || IMemAddr !== 32'h54) begin n_fail++; $display("FAIL skid_drain: got %h/%h/%b/%h exp %h/00000054/0/00000054", InstructionIFID, PCPlus4IFID, SkidValid, IMemAddr, imem(32'h50)); end
        tick();
        n_checks++; if (InstructionIFID !== imem(32'h54) || IMemAddr !== 32'h58 || FetchCount !== 32'd6) begin n_fail++; $display("FAIL skid_after: got %h/%h/%0d exp %h/00000058/6", InstructionIFID, IMemAddr, FetchCount, imem(32'h54)); end
`else
        n_checks++; if (SkidValid !== 1'b0 || IMemAddr !== 32'h50) begin n_fail++; $display("FAIL freeze_pc: got %b/%h exp 0/00000050", SkidValid, IMemAddr); end
        n_checks++; if (IFInstruction !== imem(32'h50) || InstructionIFID !== imem(32'h4C) || FetchCount !== 32'd4) begin n_fail++; $display("FAIL freeze_hold: got %h/%h/%0d exp %h/%h/4", IFInstruction, InstructionIFID, FetchCount, imem(32'h50), imem(32'h4C)); end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (InstructionIFID !== imem(32'h50) || PCPlus4IFID !== 32'h54 || IMemAddr !== 32'h54 || FetchCount !== 32'd5) begin n_fail++; $display("FAIL freeze_resume: got %h/%h/%h/%0d exp %h/00000054/00000054/5", InstructionIFID, PCPlus4IFID, IMemAddr, FetchCount, imem(32'h50)); end
`endif
    endtask

    task automatic test_flush();
        run_to_50();
        // Skid fills here when present; otherwise this is a full stall.
        drive(1'b1, 1'b0, 1'b0);
        tick();
        BranchTarget = 32'h0000_0103;
        drive(1'b0, 1'b0, 1'b1);
        tick();
        n_checks++; if (IMemAddr !== 32'h100 || ValidIFID !== 1'b0 || InstructionIFID !== 32'd0 || PCPlus4IFID !== 32'd0 || SkidValid !== 1'b0) begin n_fail++; $display("FAIL flush_state: got %h/%b/%h/%h/%b exp 00000100/0/0/0/0", IMemAddr, ValidIFID, InstructionIFID, PCPlus4IFID, SkidValid); end
        n_checks++; if (FetchCount !== 32'd4) begin n_fail++; $display("FAIL flush_count: got %0d exp 4", FetchCount); end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (InstructionIFID !== imem(32'h100) || PCPlus4IFID !== 32'h104 || ValidIFID !== 1'b1 || FetchCount !== 32'd5) begin n_fail++; $display("FAIL flush_target: got %h/%h/%b/%0d exp %h/00000104/1/5", InstructionIFID, PCPlus4IFID, ValidIFID, FetchCount, imem(32'h100)); end
    endtask

    task automatic test_reset_priority();
        run_to_50();
        drive(1'b1, 1'b0, 1'b0);
        tick();
        Rst_n = 1'b0;
        BranchTarget = 32'h0000_0200;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        Rst_n = 1'b1;
        n_checks++; if (IMemAddr !== 32'h40 || ValidIFID !== 1'b0 || SkidValid !== 1'b0 || FetchCount !== 32'd0 || InstructionIFID !== 32'd0) begin n_fail++; $display("FAIL reset_wins: got %h/%b/%b/%0d/%h exp 00000040/0/0/0/0", IMemAddr, ValidIFID, SkidValid, FetchCount, InstructionIFID); end
        drive(1'b1, 1'b1, 1'b0);
        tick();
        n_checks++; if (InstructionIFID !== 32'h2002_0005 || PCPlus4IFID !== 32'h44) begin n_fail++; $display("FAIL reset_refetch: got %h/%h exp 20020005/00000044", InstructionIFID, PCPlus4IFID); end
    endtask

    task automatic test_wrap();
        do_reset();
        n_checks++; if (w_IMemAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_reset: got %h exp fffffffc", w_IMemAddr); end
        tick();
        n_checks++; if (w_PCPlus4IFID !== 32'd0 || w_IMemAddr !== 32'd0 || w_InstructionIFID !== imem(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap: got %h/%h/%h exp 0/0/%h", w_PCPlus4IFID, w_IMemAddr, w_InstructionIFID, imem(32'hFFFF_FFFC)); end
    endtask

    initial begin
        Rst_n        = 1'b0;
        PCWrite      = 1'b0;
        IFIDWrite    = 1'b0;
        Flush        = 1'b0;
        BranchTarget = 32'd0;
        test_reset();
        test_straight_line();
        test_load_use_stall();
        test_ifid_freeze();
        test_flush();
        test_reset_priority();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the program counter, drives instruction-memory address, and holds the IF/ID pipeline register that feeds decode and the hazard unit. It consumes the hazard unit's PCWrite, IFIDWrite and Flush outputs, plus the resolved branch target. A one-entry skid buffer preserves a fetched word when IF/ID is frozen while the PC still advances, so no instruction is lost.

## Interface

- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  synchronous, active-low reset
- PCWrite  in  1  1 = PC may advance; 0 = stall PC and IF/ID
- IFIDWrite  in  1  1 = IF/ID may load; 0 = freeze IF/ID
- Flush  in  1  taken branch/jump: redirect PC, squash IF/ID
- BranchTarget  in  32  redirect address, used when Flush=1
- IMemAddr  out  32  instruction memory address (= PC register)
- IMemData  in  32  combinational instruction-memory read data for IMemAddr
- IFInstruction  out  32  word currently offered to IF/ID (skid word if SkidValid, else IMemData)
- InstructionIFID  out  32  IF/ID instruction
- PCPlus4IFID  out  32  IF/ID PC+4 of that instruction
- ValidIFID  out  1  IF/ID holds a real instruction
- SkidValid  out  1  skid buffer occupied
- FetchCount  out  32  count of valid instructions loaded into IF/ID

## Operation

- Clock Clk, reset Rst_n synchronous active-low; reset has priority over everything.
- Fetch source: SkidValid=1 -> (SkidInstr, SkidPC4); else (IMemData, PC+4).
- Per-cycle priority, evaluated at rising edge:
  - Flush=1: PC <= {BranchTarget[31:2],2'b00}; InstructionIFID <= 0 (NOP); PCPlus4IFID <= 0; ValidIFID <= 0; skid emptied. PCWrite/IFIDWrite ignored.
  - else PCWrite=0: PC, IF/ID, skid all hold.
  - else IFIDWrite=1, skid empty: IF/ID <= (IMemData, PC+4), ValidIFID <= 1; PC <= PC+4.
  - else IFIDWrite=1, skid full: IF/ID <= skid contents, ValidIFID <= 1; skid empties; PC holds.
  - else IFIDWrite=0, skid empty: skid <= (IMemData, PC+4); PC <= PC+4; IF/ID holds.
  - else IFIDWrite=0, skid full: PC, IF/ID, skid hold (backpressure).
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 0; PCPlus4 wraps identically.
- FetchCount increments by 1 on every IF/ID load with ValidIFID <= 1; wraps at 2^32; never increments on Flush or hold.

## Timing

- Reset values: PC = IMemAddr = RESET_PC; InstructionIFID = 0; PCPlus4IFID = 0; ValidIFID = 0; SkidValid = 0; skid contents = 0; FetchCount = 0.
- IMemAddr driven directly from PC register; IMemData sampled same cycle.
- Latency: word at PC appears on InstructionIFID one cycle after its address is on IMemAddr (no stalls).
- Redirect: Flush high at edge N -> IMemAddr = target after N; target instruction in IF/ID after N+1; one bubble (ValidIFID=0) in between.
- Flush with Rst_n=0 same edge: reset wins. Flush during stall or with skid full: Flush wins, skid contents discarded.
- Skid drain costs one cycle of PC hold; throughput returns to 1 instr/cycle the following cycle.
- Rst_n asserted mid-stall or with skid full: all state returns to reset values at that edge.

## Configuration

- FETCH_SKID_EN defined: skid buffer present, behaviour as above.
- FETCH_SKID_EN undefined: no skid storage; SkidValid tied 0; IFIDWrite=0 with PCWrite=1 holds PC and IF/ID (treated as full stall); IFInstruction = IMemData always.

## Test plan

- Reset: hold Rst_n=0 two cycles, RESET_PC=32'h0000_0040 -> IMemAddr=0x40, ValidIFID=0, FetchCount=0; release, IMem returns 0x2002_0005 -> next edge InstructionIFID=0x2002_0005, PCPlus4IFID=0x44.
- Straight-line: 8 cycles PCWrite=IFIDWrite=1 -> IMemAddr steps 0x40..0x5C, FetchCount=8, ValidIFID=1 continuously.
- Load-use stall: PCWrite=0 one cycle at PC=0x48 -> PC stays 0x48, IF/ID unchanged, FetchCount unchanged that edge.
- Skid (FETCH_SKID_EN): PCWrite=1, IFIDWrite=0 at PC=0x50 -> SkidValid=1, PC=0x54; next cycle IFIDWrite=1 -> InstructionIFID=IMem[0x50], PCPlus4IFID=0x54, SkidValid=0, PC still 0x54; no instruction dropped or duplicated.
- Flush: Flush=1, BranchTarget=0x0000_0103 with skid full -> PC=0x100, ValidIFID=0, InstructionIFID=0, SkidValid=0; next edge IF/ID=IMem[0x100].
- Wrap: RESET_PC=32'hFFFF_FFFC, free-run one cycle -> PCPlus4IFID=0, IMemAddr=0.
